whack_a_mole_game: RTL and testbench

- Parametrised N-channel reaction game: LFSR picks a mole, the mole's LED is lit for a timed window, and the player must press the matching button.
- Generalises the fixed 3-button, single-hit-flag design: adds channel count, timed windows, hit/miss scoring, a game-over state and restart.
- Sits directly behind the pad wrapper; buttons and LEDs map to io_in/io_out bits.

---
 rtl/whack_pkg.sv | 31 +++
 rtl/whack_a_mole_game_if.sv | 30 +++
 rtl/lfsr_gen.sv | 25 ++
 rtl/whack_a_mole_game.sv | 169 ++++++++++++++++
 tb/tb_whack_a_mole_game.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared types, tap constants and helpers for the whack-a-mole game
// Purpose: game state encoding, default LFSR tap masks, width helper.
// Ports: none (package).
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  // Fibonacci feedback masks, MSB = highest tap (bit WIDTH-1).
  localparam logic [7:0] TAPS_W5 = 8'h14;  // x^5+x^3+1
  localparam logic [7:0] TAPS_W7 = 8'h60;  // x^7+x^6+1
  localparam logic [7:0] TAPS_W8 = 8'hB8;  // x^8+x^6+x^5+x^4+1

  function automatic logic [7:0] default_taps(input int width);
    case (width)
      5:       return TAPS_W5;
      8:       return TAPS_W8;
      default: return TAPS_W7;
    endcase
  endfunction

  // Bits needed to index n values, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/whack_a_mole_game_if.sv
// rtl/whack_a_mole_game_if.sv - player-facing signal bundle of the whack-a-mole game
// Purpose: groups buttons/start (player side) and LEDs/pulses/counters (game side).
// Signals: btn, start (to game); mole_led, hit_pulse, miss_pulse, score, misses, game_over (from game).
// Modports: master = pad/player side, slave = game.
interface whack_a_mole_game_if #(
  parameter int NUM_MOLES   = 3,
  parameter int SCORE_WIDTH = 4,
  parameter int MISS_WIDTH  = 2
) ();

  logic [NUM_MOLES-1:0]   btn;
  logic                   start;
  logic [NUM_MOLES-1:0]   mole_led;
  logic                   hit_pulse;
  logic                   miss_pulse;
  logic [SCORE_WIDTH-1:0] score;
  logic [MISS_WIDTH-1:0]  misses;
  logic                   game_over;

  modport master (
    output btn, start,
    input  mole_led, hit_pulse, miss_pulse, score, misses, game_over
  );

  modport slave (
    input  btn, start,
    output mole_led, hit_pulse, miss_pulse, score, misses, game_over
  );

endinterface

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - free-running Fibonacci LFSR
// Purpose: shifts left every cycle, feedback = XOR of the TAPS-selected bits.
// Ports: clk, reset (sync, active-high, loads SEED), value (current register).
module lfsr_gen
  import whack_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] value
);

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk) begin
    if (reset) value <= SEED;
    else       value <= {value[WIDTH-2:0], feedback};
  end

endmodule

// File: rtl/whack_a_mole_game.sv
// rtl/whack_a_mole_game.sv - N-channel whack-a-mole reaction game
// Purpose: LFSR picks a mole, its LED is lit for a window, the player must press
//          the matching button; hits/misses are scored, MAX_MISSES ends the game.
// Ports: clk, reset (sync, active-high);
//        bus.btn, bus.start in; bus.mole_led, bus.hit_pulse, bus.miss_pulse,
//        bus.score, bus.misses, bus.game_over out.
// Option: WHACK_SPEEDUP_EN - each hit shortens the lit window down to a floor.
module whack_a_mole_game
  import whack_pkg::*;
#(
  parameter int                    NUM_MOLES     = 3,
  parameter int                    LFSR_WIDTH    = 7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 7'h60,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 7'h01,
  parameter int                    WINDOW_CYCLES = 16,
  parameter int                    GAP_CYCLES    = 4,
  parameter int                    SCORE_WIDTH   = 4,
  parameter int                    MAX_MISSES    = 3
) (
  input  logic               clk,
  input  logic               reset,
  whack_a_mole_game_if.slave bus
);

  localparam int IW = clog2_min1(NUM_MOLES);
  localparam int MW = clog2_min1(MAX_MISSES + 1);
  localparam int TW = clog2_min1((WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES);

  state_t                 state, state_nx;
  logic [NUM_MOLES-1:0]   btn_q, press, target;
  logic                   start_q, start_edge;
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic                   lfsr_unused;
  logic [IW-1:0]          idx_raw, idx_nx, mole_idx;
  logic [TW-1:0]          timer;
  logic [SCORE_WIDTH-1:0] score;
  logic [MW-1:0]          misses;
  logic                   hit, miss, hit_q, miss_q;

  lfsr_gen #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  // Only the low bits choose the mole; the rest just carry the sequence.
  assign lfsr_unused = ^lfsr[LFSR_WIDTH-1:IW];
  assign idx_raw     = lfsr[IW-1:0];
  assign idx_nx      = (int'(idx_raw) >= NUM_MOLES) ? idx_raw - IW'(NUM_MOLES) : idx_raw;
  assign target      = NUM_MOLES'(1) << mole_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q   <= '0;
      start_q <= 1'b0;
    end else begin
      btn_q   <= bus.btn;
      start_q <= bus.start;
    end
  end

  assign press      = bus.btn & ~btn_q;
  assign start_edge = bus.start & ~start_q;

`ifdef WHACK_SPEEDUP_EN
  localparam int WIN_STEP  = (WINDOW_CYCLES / 8 > 0) ? WINDOW_CYCLES / 8 : 1;
  localparam int WIN_FLOOR = (WINDOW_CYCLES / 4 > 0) ? WINDOW_CYCLES / 4 : 1;
  logic [TW:0] window_len;

  always_ff @(posedge clk) begin
    if (reset || start_edge)
      window_len <= (TW+1)'(WINDOW_CYCLES);
    else if (hit)
      window_len <= (window_len >= (TW+1)'(WIN_FLOOR + WIN_STEP))
                    ? window_len - (TW+1)'(WIN_STEP) : (TW+1)'(WIN_FLOOR);
  end
`else
  localparam logic [TW:0] window_len = (TW+1)'(WINDOW_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A start edge restarts from any state; in SHOW an exact single correct press
  // is a hit, any other press (or the window expiring) is a miss.
  always_comb begin
    state_nx = state;
    hit      = 1'b0;
    miss     = 1'b0;
    if (start_edge) begin
      state_nx = GAP;
    end else begin
      case (state)
        GAP: if (timer == '0) state_nx = SHOW;
        SHOW: begin
          if (press == target)                 hit  = 1'b1;
          else if (press != '0 || timer == '0) miss = 1'b1;
          if (hit)
            state_nx = GAP;
          else if (miss)
            state_nx = (misses == MW'(MAX_MISSES - 1)) ? OVER : GAP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      mole_idx <= '0;
      score    <= '0;
      misses   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_q  <= hit;
      miss_q <= miss;
      if (start_edge) begin
        score  <= '0;
        misses <= '0;
        timer  <= TW'(GAP_CYCLES - 1);
      end else begin
        if (state == GAP) begin
          if (timer == '0) begin
            mole_idx <= idx_nx;
            timer    <= TW'(window_len - 1'b1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        if (state == SHOW) timer <= timer - 1'b1;
        if (hit) begin
          if (score != '1) score <= score + 1'b1;
          timer <= TW'(GAP_CYCLES - 1);
        end
        if (miss) begin
          misses <= misses + 1'b1;
          timer  <= TW'(GAP_CYCLES - 1);
        end
      end
    end
  end

  always_comb begin
    bus.mole_led  = '0;
    bus.game_over = 1'b0;
    case (state)
      SHOW: bus.mole_led = target;
      OVER: begin
        bus.mole_led  = '1;
        bus.game_over = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score      = score;
  assign bus.misses     = misses;

endmodule

// File: tb/tb_whack_a_mole_game.sv
// tb/tb_whack_a_mole_game.sv - directed self-checking bench for whack_a_mole_game
module tb_whack_a_mole_game;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   exp_window;
  int   n;
  logic [2:0] led_save;

  whack_a_mole_game_if #(.NUM_MOLES(3), .SCORE_WIDTH(4), .MISS_WIDTH(2)) bus ();
  whack_a_mole_game_if #(.NUM_MOLES(5), .SCORE_WIDTH(4), .MISS_WIDTH(2)) bus5 ();

  whack_a_mole_game #(.NUM_MOLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  whack_a_mole_game #(.NUM_MOLES(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference x^7+x^6+1 sequence; lfsr_prev is the value seen before the last edge.
  logic [6:0] lfsr_m, lfsr_prev;
  always @(posedge clk) begin
    if (reset) lfsr_m <= 7'h01;
    else       lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    lfsr_prev <= lfsr_m;
  end

  function automatic logic [2:0] exp_led3(input logic [6:0] v);
    int idx;
    idx = int'(v[1:0]);
    if (idx >= 3) idx = idx - 3;
    return 3'(1 << idx);
  endfunction

  function automatic logic [4:0] exp_led5(input logic [6:0] v);
    int idx;
    idx = int'(v[2:0]);
    if (idx >= 5) idx = idx - 5;
    return 5'(1 << idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic note_hit();
`ifdef WHACK_SPEEDUP_EN
    exp_window = (exp_window >= 6) ? exp_window - 2 : 4;
`endif
  endtask

  // Counts dark cycles, including the current one, until a mole lights.
  task automatic wait_show(output int dark);
    dark = 0;
    while (bus.mole_led == 0 && dark < 100) begin
      dark++;
      @(negedge clk);
    end
  endtask

  // Counts lit cycles, including the current one, until the mole goes dark or game over.
  task automatic wait_dark(output int lit);
    lit = 0;
    while (bus.mole_led != 0 && !bus.game_over && lit < 100) begin
      lit++;
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_window = 16;
    reset = 1'b1;
    bus.btn = '0;
    bus.start = 1'b0;
    bus5.btn = '0;
    bus5.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_led", bus.mole_led, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_misses", bus.misses, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);

    // start -> 4 dark GAP cycles -> first mole
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_show(n);
    chk("gap_len", n, 4);
    chk("mole1", bus.mole_led, exp_led3(lfsr_prev));
    chk("start_score", bus.score, 0);

    // correct press in the third SHOW cycle
    repeat (2) @(negedge clk);
    bus.btn = bus.mole_led;
    @(negedge clk);
    chk("hit_pulse", bus.hit_pulse, 1);
    chk("hit_nomiss", bus.miss_pulse, 0);
    chk("hit_score", bus.score, 1);
    chk("hit_led_off", bus.mole_led, 0);
    note_hit();
    @(negedge clk);
    bus.btn = '0;
    chk("hit_pulse_width", bus.hit_pulse, 0);
    wait_show(n);
    chk("gap_after_hit", n, 3);  // first GAP cycle already observed above
    chk("mole2", bus.mole_led, exp_led3(lfsr_prev));

    // wrong button
    bus.btn = {bus.mole_led[1:0], bus.mole_led[2]};
    @(negedge clk);
    chk("wrong_miss", bus.miss_pulse, 1);
    chk("wrong_nohit", bus.hit_pulse, 0);
    chk("wrong_misses", bus.misses, 1);
    bus.btn = '0;

    // two timeouts -> OVER
    wait_show(n);
    wait_dark(n);
    chk("timeout1_len", n, exp_window);
    chk("timeout1_miss", bus.miss_pulse, 1);
    chk("timeout1_misses", bus.misses, 2);
    wait_show(n);
    wait_dark(n);
    chk("timeout2_len", n, exp_window);
    chk("over_miss", bus.miss_pulse, 1);
    chk("over_misses", bus.misses, 3);
    chk("over_flag", bus.game_over, 1);
    chk("over_led", bus.mole_led, 3'b111);
    chk("over_score", bus.score, 1);
    @(negedge clk);
    chk("over_hold", {bus.game_over, bus.miss_pulse}, 2'b10);

    // restart from OVER clears the counters
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_window = 16;
    chk("restart_score", bus.score, 0);
    chk("restart_misses", bus.misses, 0);
    chk("restart_over", bus.game_over, 0);
    chk("restart_led", bus.mole_led, 0);

    // correct + wrong in one cycle, then keep them held across the next window
    wait_show(n);
    chk("mole3", bus.mole_led, exp_led3(lfsr_prev));
    bus.btn = 3'b111;
    @(negedge clk);
    chk("combo_miss", bus.miss_pulse, 1);
    chk("combo_nohit", bus.hit_pulse, 0);
    chk("combo_score", bus.score, 0);
    wait_show(n);
    wait_dark(n);
    chk("held_no_press", n, exp_window);
    chk("held_misses", bus.misses, 2);
    bus.btn = '0;

    // 16 hits saturate a 4-bit score
    for (int i = 0; i < 16; i++) begin
      wait_show(n);
      chk("mole_seq", bus.mole_led, exp_led3(lfsr_prev));
      bus.btn = bus.mole_led;
      @(negedge clk);
      chk("seq_hit", bus.hit_pulse, 1);
      note_hit();
      bus.btn = '0;
    end
    chk("score_sat", bus.score, 15);
    chk("sat_misses", bus.misses, 2);

    // press on the last lit cycle wins over the timeout
    wait_show(n);
    led_save = bus.mole_led;
    repeat (exp_window - 1) @(negedge clk);
    chk("last_cycle_lit", bus.mole_led, led_save);
    bus.btn = bus.mole_led;
    @(negedge clk);
    chk("last_hit", bus.hit_pulse, 1);
    chk("last_nomiss", bus.miss_pulse, 0);
    chk("last_misses", bus.misses, 2);
    chk("last_score", bus.score, 15);
    note_hit();
    bus.btn = '0;

    // reset mid-SHOW together with a press: no pulse, everything cleared
    wait_show(n);
    bus.btn = bus.mole_led;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);
    chk("midrst_score", bus.score, 0);
    chk("midrst_misses", bus.misses, 0);
    chk("midrst_led", bus.mole_led, 0);
    reset = 1'b0;
    bus.btn = '0;
    exp_window = 16;

`ifdef WHACK_SPEEDUP_EN
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_show(n);
      bus.btn = bus.mole_led;
      @(negedge clk);
      bus.btn = '0;
    end
    wait_show(n);
    wait_dark(n);
    chk("window_floor", n, 4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_show(n);
    wait_dark(n);
    chk("window_restart", n, 16);
`endif

    // 5-channel instance: every mole index stays below 5
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (bus5.mole_led == 0 && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk("mole5", bus5.mole_led, exp_led5(lfsr_prev));
      bus5.btn = bus5.mole_led;
      @(negedge clk);
      bus5.btn = '0;
    end
    chk("mole5_misses", bus5.misses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
